// File: rtl/ann_pkg.sv
// Shared types and constants for the ANN datapath neuron blocks.
//   state_t : neuron accumulator FSM states (ACC, FIN, OUT)
//   SUM_W   : width of the partial sum delivered by the adder stage
//   ACT_W   : width of one activation
//   SAT_MAX : value an activation is clamped to on overflow
package ann_pkg;

    localparam int SUM_W = 17;
    localparam int ACT_W = 16;
    localparam logic [ACT_W-1:0] SAT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } state_t;

endpackage

// File: rtl/neuron_accum_if.sv
// Stream bundle between the adder stage, the neuron accumulator and the next layer.
//   sum_in/in_valid/in_ready        : partial-sum handshake, sum_in bit 0 = MSB
//   act_out/out_valid/out_ready     : activation handshake, act_out bit 0 = MSB
//   sat_flag                        : activation was clamped, qualified by out_valid
//   busy                            : a neuron is in progress
// slave modport = the accumulator, master modport = its environment.
interface neuron_accum_if;
    import ann_pkg::*;

    logic [0:SUM_W-1] sum_in;
    logic             in_valid;
    logic             in_ready;
    logic [0:ACT_W-1] act_out;
    logic             out_valid;
    logic             out_ready;
    logic             sat_flag;
    logic             busy;

    modport slave (
        input  sum_in, in_valid, out_ready,
        output in_ready, act_out, out_valid, sat_flag, busy
    );

    modport master (
        output sum_in, in_valid, out_ready,
        input  in_ready, act_out, out_valid, sat_flag, busy
    );

endinterface

// File: rtl/neuron_sat.sv
// Combinational scaling of the final accumulator into one activation.
// Shifts right by SHIFT, optionally applies a thresholded ReLU, then clamps to 16 bits.
//   acc : accumulator value (ACC_W bits)
//   act : resulting activation (16 bits)
//   sat : high when act was clamped to SAT_MAX
// Optional feature macro: NEURON_THRESH_EN (thresholded ReLU with THRESH).
module neuron_sat
    import ann_pkg::*;
#(
    parameter int               ACC_W  = 20,
    parameter int               SHIFT  = 3,
    parameter logic [ACT_W-1:0] THRESH = 16'd0
) (
    input  logic [ACC_W-1:0] acc,
    output logic [ACT_W-1:0] act,
    output logic             sat
);

    localparam logic [ACC_W-1:0] MAX_W = ACC_W'(SAT_MAX);

    logic [ACC_W-1:0] r;
    logic [ACC_W-1:0] t;

    always_comb begin
        r = acc >> SHIFT;
`ifdef NEURON_THRESH_EN
        // The clamp runs after the threshold, so only a genuinely large result saturates.
        if (r <= ACC_W'(THRESH)) begin
            t = '0;
        end else begin
            t = r - ACC_W'(THRESH);
        end
`else
        t = r;
`endif
        if (t > MAX_W) begin
            act = SAT_MAX;
            sat = 1'b1;
        end else begin
            act = t[ACT_W-1:0];
            sat = 1'b0;
        end
    end

`ifndef NEURON_THRESH_EN
    logic [ACT_W-1:0] unused_thresh;
    assign unused_thresh = THRESH;
`endif

endmodule

// File: rtl/neuron_accum.sv
// Neuron accumulator: sums N_TERMS partial sums, scales/saturates, emits one activation.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any neuron in progress
//   bus   : neuron_accum_if.slave (input stream, output stream, sat_flag, busy)
// Optional feature macro: NEURON_THRESH_EN (handled inside neuron_sat).
//
// state | meaning
// ------+-----------------------------------------------------------
// ACC   | accepting partial sums, in_ready = 1
// FIN   | one cycle: register scaled/saturated activation, clear acc
// OUT   | out_valid = 1, hold act_out/sat_flag until out_ready
module neuron_accum
    import ann_pkg::*;
#(
    parameter int               N_TERMS = 8,
    parameter int               ACC_W   = 20,
    parameter int               SHIFT   = 3,
    parameter logic [ACT_W-1:0] THRESH  = 16'd0
) (
    input  logic           clk,
    input  logic           rst_n,
    neuron_accum_if.slave  bus
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACT_W-1:0] act_q;
    logic             sat_q;
    logic [ACT_W-1:0] sat_act;
    logic             sat_hit;
    logic [SUM_W-1:0] sum_val;
    logic             take;
    logic             last_term;
    logic             in_ready_c;
    logic             out_valid_c;

    // [0:16] port ordering maps positionally, so sum_val keeps the same numeric value.
    assign sum_val   = bus.sum_in;
    assign take      = bus.in_valid && in_ready_c;
    assign last_term = take && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            ST_ACC: begin
                in_ready_c = 1'b1;
                if (last_term) begin
                    state_nx = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nx = ST_OUT;
            end
            ST_OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nx = ST_ACC;
                end
            end
            default: begin
                state_nx = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            act_q <= '0;
            sat_q <= 1'b0;
        end else begin
            if (take) begin
                acc <= acc + ACC_W'(sum_val);
                cnt <= last_term ? '0 : cnt + 1'b1;
            end
            if (state == ST_FIN) begin
                act_q <= sat_act;
                sat_q <= sat_hit;
                acc   <= '0;
            end
        end
    end

    neuron_sat #(
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT),
        .THRESH (THRESH)
    ) u_sat (
        .acc (acc),
        .act (sat_act),
        .sat (sat_hit)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.act_out   = act_q;
    assign bus.sat_flag  = sat_q;
    assign bus.busy      = (state != ST_ACC) || (cnt != '0);

endmodule

// File: tb/tb_neuron_accum.sv
// Self-checking bench for neuron_accum (N_TERMS=8, ACC_W=20, SHIFT=3, THRESH=50).
// Expected activations come from a bench-side model pushed to a scoreboard queue
// whenever the eighth term of a neuron is accepted; they are popped on each output
// handshake. Builds with or without NEURON_THRESH_EN.
module tb_neuron_accum;

    localparam int N_TERMS = 8;
    localparam int ACC_W   = 20;
    localparam int SHIFT   = 3;
    localparam logic [15:0] THRESH = 16'd50;
    localparam int LIMIT   = 200;

`ifdef NEURON_THRESH_EN
    localparam int EXP_BASIC = 50;
    localparam int EXP_BP2   = 38;
    localparam int EXP_GAP   = 0;
    localparam int EXP_RST   = 0;
    localparam int EXP_LOW   = 0;
`else
    localparam int EXP_BASIC = 100;
    localparam int EXP_BP2   = 88;
    localparam int EXP_GAP   = 36;
    localparam int EXP_RST   = 8;
    localparam int EXP_LOW   = 40;
`endif

    logic clk;
    logic rst_n;

    neuron_accum_if bus ();

    neuron_accum #(
        .N_TERMS (N_TERMS),
        .ACC_W   (ACC_W),
        .SHIFT   (SHIFT),
        .THRESH  (THRESH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int m_acc   = 0;
    int m_cnt   = 0;
    logic [15:0] last_act;
    logic        last_sat;
    logic [16:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference scaling: {sat, act}
    function automatic logic [16:0] model(input int total);
        int r;
        r = total >>> SHIFT;
`ifdef NEURON_THRESH_EN
        if (r <= int'(THRESH)) r = 0;
        else r = r - int'(THRESH);
`endif
        if (r > 65535) return {1'b1, 16'hFFFF};
        return {1'b0, r[15:0]};
    endfunction

    // Inputs change only just after posedge, so negedge sees what the next edge will take.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_acc = 0;
            m_cnt = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                m_acc += int'(bus.sum_in);
                m_cnt++;
                if (m_cnt == N_TERMS) begin
                    sb_q.push_back(model(m_acc));
                    m_acc = 0;
                    m_cnt = 0;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                logic [16:0] e;
                check("sb_nonempty", (sb_q.size() > 0), 1);
                e = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h0;
                check("sb_act", bus.act_out, e[15:0]);
                check("sb_sat", bus.sat_flag, e[16]);
                last_act = bus.act_out;
                last_sat = bus.sat_flag;
                n_out++;
            end
        end
    end

    task automatic send_term(input logic [16:0] v);
        int n = 0;
        bus.sum_in   = v;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("in_bound", (n < LIMIT), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_n(input logic [16:0] v, input int count);
        for (int i = 0; i < count; i++) send_term(v);
    endtask

    task automatic wait_out(input int prev);
        int n = 0;
        while (n_out == prev && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("out_bound", (n_out != prev), 1);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_act_out",   bus.act_out,   0);
        check("rst_sat_flag",  bus.sat_flag,  0);
        check("rst_busy",      bus.busy,      0);
    endtask

    initial begin
        int prev;
        rst_n         = 1'b0;
        bus.sum_in    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic with latency
        prev = n_out;
        send_n(17'd100, N_TERMS);
        check("lat_fin_valid", bus.out_valid, 0);
        check("lat_fin_ready", bus.in_ready, 0);
        check("lat_fin_busy",  bus.busy, 1);
        @(posedge clk);
        #1;
        check("lat_out_valid", bus.out_valid, 1);
        wait_out(prev);
        check("basic_act", last_act, EXP_BASIC);
        check("basic_sat", last_sat, 0);

        // Saturation
        prev = n_out;
        send_n(17'h1FFFF, N_TERMS);
        wait_out(prev);
        check("satur_act", last_act, 16'hFFFF);
        check("satur_sat", last_sat, 1);

        // Backpressure with a ninth term waiting
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        prev = n_out;
        send_n(17'd100, N_TERMS);
        fork
            send_term(17'd7);
            begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_out_valid", bus.out_valid, 1);
                    check("bp_act_hold",  bus.act_out, EXP_BASIC);
                    check("bp_in_ready",  bus.in_ready, 0);
                    check("bp_busy",      bus.busy, 1);
                end
                check("bp_no_early_take", m_cnt, 0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        check("bp_out_count", n_out, prev + 1);
        check("bp_act", last_act, EXP_BASIC);
        check("bp_ninth_taken", m_cnt, 1);
        prev = n_out;
        send_n(17'd100, N_TERMS - 1);
        wait_out(prev);
        check("bp_next_act", last_act, EXP_BP2);

        // Gapped input
        prev = n_out;
        for (int i = 1; i <= N_TERMS; i++) begin
            send_term(17'(8 * i));
            @(posedge clk);
            #1;
            if (i < N_TERMS) check("gap_busy", bus.busy, 1);
        end
        wait_out(prev);
        check("gap_act", last_act, EXP_GAP);
        check("gap_sat", last_sat, 0);

        // Reset mid-operation
        send_n(17'd1000, 4);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev = n_out;
        send_n(17'd8, N_TERMS);
        wait_out(prev);
        check("rst_act", last_act, EXP_RST);
        check("rst_sat", last_sat, 0);

        // Below threshold when the feature is on
        prev = n_out;
        send_n(17'd40, N_TERMS);
        wait_out(prev);
        check("low_act", last_act, EXP_LOW);
        check("low_sat", last_sat, 0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        check("idle_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
